// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: write-back source select and load-type encodings.
package rv32_pkg;

  // Register-file write-back source
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_MUL  = 2'b11
  } wb_sel_e;

  // Load type, taken straight from funct3
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/writeback_pipe_load_align.sv
// Combinational load alignment: picks the byte/halfword lane out of a raw
// memory word and sign- or zero-extends it. Kept separate so the store path
// can reuse the lane selection.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection: byte by full offset, halfword by offset[1] only
  always_comb begin
    byte_lane = rdata[7:0];
    case (offset)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension per load type; unknown encodings behave as a full-word load
  always_comb begin
    case (op)
      LD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      LD_LBU:  data = {24'h0, byte_lane};
      LD_LH:   data = {{16{half_lane[15]}}, half_lane};
      LD_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_pipe.sv
// Write-back stage: registers MEM-stage results, aligns load data, selects the
// write-back source, drives the register-file write port and counts retired
// instructions.
module writeback_pipe
  import rv32_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core_N,
  input  logic                 valid_di,
  input  logic                 flush_di,
  input  logic [4:0]           rd_addr_di,
  input  logic                 reg_wr_en_di,
  input  logic [1:0]           reg_wb_sel_di,
  input  logic [2:0]           lw_sw_op_di,
  input  logic [DWIDTH-1:0]    alu_result_di,
  input  logic [DWIDTH-1:0]    mem_rdata_di,
  input  logic [DWIDTH-1:0]    mul_result_di,
  input  logic [DWIDTH-1:0]    pc_plus_di,
  output logic [4:0]           wr_addr_1_do,
  output logic [DWIDTH-1:0]    wr_data_1_do,
  output logic                 reg_wr_en_do,
  output logic                 wb_valid_do,
  output logic [CNT_WIDTH-1:0] instret_do
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 valid_q;
  logic [4:0]           rd_q;
  logic                 wr_en_q;
  wb_sel_e              sel_q;
  logic [2:0]           op_q;
  logic [DWIDTH-1:0]    alu_q;
  logic [DWIDTH-1:0]    mem_q;
  logic [DWIDTH-1:0]    mul_q;
  logic [DWIDTH-1:0]    pc_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [DWIDTH-1:0]    load_data;
  logic [DWIDTH-1:0]    wb_data;

  // Stage register: a flush turns the captured entry into a bubble, payload always loads
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      valid_q <= 1'b0;
      rd_q    <= 5'd0;
      wr_en_q <= 1'b0;
      sel_q   <= WB_ALU;
      op_q    <= 3'd0;
      alu_q   <= '0;
      mem_q   <= '0;
      mul_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_di & ~flush_di;
      rd_q    <= rd_addr_di;
      wr_en_q <= reg_wr_en_di;
      sel_q   <= wb_sel_e'(reg_wb_sel_di);
      op_q    <= lw_sw_op_di;
      alu_q   <= alu_result_di;
      mem_q   <= mem_rdata_di;
      mul_q   <= mul_result_di;
      pc_q    <= pc_plus_di;
    end
  end

  // Retired-instruction counter: one per edge with a valid entry in WB, wraps freely
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      instret_q <= '0;
    end else if (valid_q) begin
      instret_q <= instret_q + CNT_ONE;
    end
  end

  load_align u_load_align (
    .rdata  (mem_q),
    .offset (alu_q[1:0]),
    .op     (op_q),
    .data   (load_data)
  );

  // Write-back source mux
  always_comb begin
    case (sel_q)
      WB_ALU:  wb_data = alu_q;
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = pc_q;
      WB_MUL:  wb_data = mul_q;
      default: wb_data = alu_q;
    endcase
  end

  assign wr_addr_1_do = rd_q;
  assign wr_data_1_do = wb_data;
  assign reg_wr_en_do = valid_q & wr_en_q & (rd_q != 5'd0);
  assign wb_valid_do  = valid_q;
  assign instret_do   = instret_q;

endmodule
